// File: rtl/jzjpcc_ram_arbiter_if.sv
// Bus bundle between the pipeline requesters, the debug port, the SRAM and
// the RAM arbiter. The arbiter is the slave side; the master side is
// everything around it (fetch, memory stage, debugger and the SRAM itself).
interface jzjpcc_ram_arbiter_if #(
  parameter int PC_MAX_B = 13
);
  // instruction fetch port
  logic              fetchReq;
  logic [PC_MAX_B:2] fetchAddr;
  logic              fetchGrant;
  logic              fetchRValid;
  // memory-stage data port
  logic              dataReq;
  logic              dataWE;
  logic [PC_MAX_B:2] dataAddr;
  logic [31:0]       dataWData;
  logic [3:0]        dataByteEn;
  logic              dataGrant;
  logic              dataRValid;
  // debug / loader port
  logic              dbgReq;
  logic              dbgWE;
  logic [PC_MAX_B:2] dbgAddr;
  logic [31:0]       dbgWData;
  logic [3:0]        dbgByteEn;
  logic              dbgGrant;
  logic              dbgRValid;
  // pipeline freeze
  logic              haltCore;
  // SRAM side
  logic [PC_MAX_B:2] ramAddr;
  logic              ramWE;
  logic [31:0]       ramWData;
  logic [3:0]        ramByteEn;
  logic [31:0]       ramRData;
  // shared read data
  logic [31:0]       rData;

  modport slave (
    input  fetchReq, fetchAddr,
    output fetchGrant, fetchRValid,
    input  dataReq, dataWE, dataAddr, dataWData, dataByteEn,
    output dataGrant, dataRValid,
    input  dbgReq, dbgWE, dbgAddr, dbgWData, dbgByteEn,
    output dbgGrant, dbgRValid,
    output haltCore,
    output ramAddr, ramWE, ramWData, ramByteEn,
    input  ramRData,
    output rData
  );

  modport master (
    output fetchReq, fetchAddr,
    input  fetchGrant, fetchRValid,
    output dataReq, dataWE, dataAddr, dataWData, dataByteEn,
    input  dataGrant, dataRValid,
    output dbgReq, dbgWE, dbgAddr, dbgWData, dbgByteEn,
    input  dbgGrant, dbgRValid,
    input  haltCore,
    input  ramAddr, ramWE, ramWData, ramByteEn,
    output ramRData,
    input  rData
  );
endinterface

// File: rtl/jzjpcc_ram_arbiter.sv
// Single-cycle arbiter sharing one synchronous single-ported SRAM between
// instruction fetch, the memory-stage data port and the debug port. Data has
// priority but fetch is forced through after STARVE_LIMIT denied cycles.
// A RUN/DRAIN/DEBUG sequencer freezes the pipeline for debugger access; the
// one-cycle DRAIN lets a read issued in the last RUN cycle return its data.
module jzjpcc_ram_arbiter #(
  parameter int RAM_A_WIDTH  = 12,
  parameter int PC_MAX_B     = RAM_A_WIDTH + 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clock,
  input logic                reset,
  jzjpcc_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DEBUG = 2'd2
  } state_t;

  // Who owns the read data returning from the SRAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2,
    OWN_DBG   = 2'd3
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam int         AW         = PC_MAX_B - 1;

  state_t            state_r;
  state_t            state_next_s;
  owner_t            owner_r;
  owner_t            owner_next_s;
  logic [3:0]        starve_cnt_r;
  logic [3:0]        starve_cnt_next_s;
  logic [PC_MAX_B:2] last_addr_r;
  logic [31:0]       last_wdata_r;

  logic              fetch_grant_s;
  logic              data_grant_s;
  logic              dbg_grant_s;
  logic [PC_MAX_B:2] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic              sel_we_s;
  logic [3:0]        sel_be_s;

  // Grant selection: priority arbitration in RUN, debug-only in DEBUG, none in DRAIN or reset.
  always_comb begin
    fetch_grant_s = 1'b0;
    data_grant_s  = 1'b0;
    dbg_grant_s   = 1'b0;
    if (reset) begin
      fetch_grant_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.dataReq && (starve_cnt_r < STARVE_LIM)) begin
            data_grant_s = 1'b1;
          end else if (bus.fetchReq) begin
            fetch_grant_s = 1'b1;
          end else if (bus.dataReq) begin
            data_grant_s = 1'b1;
          end else begin
            data_grant_s = 1'b0;
          end
        end
        ST_DRAIN: dbg_grant_s = 1'b0;
        ST_DEBUG: dbg_grant_s = bus.dbgReq;
        default:  dbg_grant_s = 1'b0;
      endcase
    end
  end

  // SRAM request mux; address and write data hold their last value when idle.
  always_comb begin
    sel_addr_s  = last_addr_r;
    sel_wdata_s = last_wdata_r;
    sel_we_s    = 1'b0;
    sel_be_s    = 4'b0000;
    if (fetch_grant_s) begin
      sel_addr_s = bus.fetchAddr;
    end else if (data_grant_s) begin
      sel_addr_s  = bus.dataAddr;
      sel_wdata_s = bus.dataWData;
      sel_we_s    = bus.dataWE;
      sel_be_s    = bus.dataByteEn;
    end else if (dbg_grant_s) begin
      sel_addr_s  = bus.dbgAddr;
      sel_wdata_s = bus.dbgWData;
      sel_we_s    = bus.dbgWE;
      sel_be_s    = bus.dbgByteEn;
    end else begin
      sel_we_s = 1'b0;
    end
  end

  // Halt sequencer next state: RUN -> DRAIN on a debug request, DRAIN always moves on.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.dbgReq) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: state_next_s = ST_DEBUG;
      ST_DEBUG: begin
        if (bus.dbgReq) begin
          state_next_s = ST_DEBUG;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Fetch starvation counter and read-owner tag for the next cycle.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    owner_next_s      = OWN_NONE;
    if (state_r == ST_DEBUG) begin
      starve_cnt_next_s = 4'd0;
    end else if (fetch_grant_s || !bus.fetchReq) begin
      starve_cnt_next_s = 4'd0;
    end else if (starve_cnt_r >= STARVE_LIM) begin
      starve_cnt_next_s = STARVE_LIM;
    end else begin
      starve_cnt_next_s = starve_cnt_r + 4'd1;
    end
    if (fetch_grant_s) begin
      owner_next_s = OWN_FETCH;
    end else if (data_grant_s && !bus.dataWE) begin
      owner_next_s = OWN_DATA;
    end else if (dbg_grant_s && !bus.dbgWE) begin
      owner_next_s = OWN_DBG;
    end else begin
      owner_next_s = OWN_NONE;
    end
  end

  // State, counter, owner tag and held RAM address/data registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_RUN;
      owner_r      <= OWN_NONE;
      starve_cnt_r <= 4'd0;
      last_addr_r  <= {AW{1'b0}};
      last_wdata_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      owner_r      <= owner_next_s;
      starve_cnt_r <= starve_cnt_next_s;
      last_addr_r  <= sel_addr_s;
      last_wdata_r <= sel_wdata_s;
    end
  end

  // Output drive; a cycle with reset high presents reset values everywhere.
  always_comb begin
    bus.fetchGrant  = fetch_grant_s;
    bus.dataGrant   = data_grant_s;
    bus.dbgGrant    = dbg_grant_s;
    bus.fetchRValid = !reset && (owner_r == OWN_FETCH);
    bus.dataRValid  = !reset && (owner_r == OWN_DATA);
    bus.dbgRValid   = !reset && (owner_r == OWN_DBG);
    bus.haltCore    = !reset && (state_r != ST_RUN);
    bus.ramWE       = sel_we_s;
    bus.ramByteEn   = sel_be_s;
    bus.rData       = bus.ramRData;
    if (reset) begin
      bus.ramAddr  = {AW{1'b0}};
      bus.ramWData = 32'h0000_0000;
    end else begin
      bus.ramAddr  = sel_addr_s;
      bus.ramWData = sel_wdata_s;
    end
  end

endmodule

// File: doc/jzjpcc_ram_arbiter.md
# jzjpcc_ram_arbiter

Single-cycle arbiter that shares the core's single-ported synchronous code/data SRAM between three requesters: instruction fetch, the memory stage data port and an external debug/loader port. It sits between the pipeline stages and the RAM. It grants at most one access per cycle, routes 1-cycle-latency read data back to the owner, and prevents fetch starvation. It also sequences a RUN/DRAIN/DEBUG halt so a debugger can read and write RAM while the pipeline is frozen.

## Interface
Parameters:
- RAM_A_WIDTH, 12, log2 of RAM size in 32-bit words
- PC_MAX_B, RAM_A_WIDTH + 1, MSB of all word addresses (addresses are [PC_MAX_B:2])
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fetchReq / fetchAddr  in  1 / [PC_MAX_B:2]  instruction read request
- fetchGrant  out  1  fetch access issued this cycle
- fetchRValid  out  1  fetch read data valid on rData
- dataReq / dataWE / dataAddr / dataWData / dataByteEn  in  1 / 1 / [PC_MAX_B:2] / 32 / 4  memory-stage access
- dataGrant / dataRValid  out  1 / 1
- dbgReq / dbgWE / dbgAddr / dbgWData / dbgByteEn  in  1 / 1 / [PC_MAX_B:2] / 32 / 4  debug access; holding dbgReq high requests halt
- dbgGrant / dbgRValid  out  1 / 1
- haltCore  out  1  pipeline must freeze all stage registers
- ramAddr / ramWE / ramWData / ramByteEn  out  [PC_MAX_B:2] / 1 / 32 / 4  to SRAM
- ramRData  in  32  SRAM read data, valid the cycle after the address
- rData  out  32  ramRData passed through to all requesters

## Operation
- States: RUN, DRAIN, DEBUG.
- Grants are combinational from requests and registered state. Exactly zero or one grant per cycle.
- RAM outputs mux the granted requester. With no grant: ramWE=0, ramByteEn=0, ramAddr and ramWData hold the last value.
- RUN arbitration:
  - dataReq and starveCnt<STARVE_LIMIT → data wins.
  - Otherwise fetchReq → fetch wins.
  - Otherwise dataReq → data wins.
- starveCnt (4 bits):
  - Cleared on fetchGrant or !fetchReq.
  - +1 when fetchReq && !fetchGrant.
  - Saturates at STARVE_LIMIT.
- RUN→DRAIN when dbgReq=1. Arbitration still proceeds normally in that cycle, and dbgGrant=0 in RUN.
- DRAIN: no grants. Lasts exactly one cycle so any read issued in the last RUN cycle returns. DRAIN→DEBUG unconditionally.
- DEBUG: dbgGrant=dbgReq. Fetch and data are never granted. starveCnt is held at 0. DEBUG→RUN when dbgReq=0.
- haltCore = (state != RUN). It is registered via state, so it rises one cycle after dbgReq is first sampled.
- Read ownership: a 2-bit owner tag is registered for granted reads (WE=0). The matching xRValid is 1 the next cycle. Writes never produce rvalid.
- Reset overrides everything. State→RUN, starveCnt=0, owner tag cleared, so an in-flight read produces no rvalid.

## Timing
- Reset values: every grant, every rvalid, haltCore, ramWE and ramByteEn are 0. ramAddr=0, ramWData=0.
- Read latency: grant in cycle N → xRValid and rData valid in cycle N+1.
- Throughput: one access per cycle. Back-to-back grants to the same or different requesters are allowed.
- Write: committed at the clock edge ending the grant cycle. A read of the same address granted the next cycle returns the new data.
- Halt entry: dbgReq sampled high at edge E → DRAIN after E → DEBUG after E+1. The first dbgGrant is possible in the cycle after E+1.
- Halt exit: dbgReq low in DEBUG → RUN next cycle, and fetch and data may be granted in that same cycle.
- dbgReq dropped during DRAIN: DEBUG is still entered for one cycle, then RUN.
- Requesters must hold request and address stable until granted. A denied request produces no side effects.

## Test plan
- After reset, fetchReq=1 with fetchAddr=0x010 → fetchGrant=1 the same cycle, ramAddr=0x010. fetchRValid=1 next cycle with rData equal to the preloaded word.
- dataReq and fetchReq both held continuously, STARVE_LIMIT=4 → data is granted 4 cycles, then fetch 1 cycle, repeating. starveCnt never exceeds 4.
- Data write 0xDEADBEEF with dataByteEn=4'b0011 to 0x020 (old value 0x11223344), then a data read of 0x020 the next cycle → rData=0x1122BEEF.
- Read granted to data while dbgReq rises in the same cycle → dataRValid=1 in DRAIN. haltCore=1 from DRAIN on. No fetch/data grants until dbgReq falls. A debug write then read of 0x030 returns the written value.
- Fetch read granted, then reset asserted in the next cycle → fetchRValid=0, and all outputs hold reset values that cycle.
- Reset asserted while in DEBUG → RUN and haltCore=0 after the edge. Fetch is granted immediately if requested.
